vga_map_write_arbiter: RTL and testbench

//   Owns the single write port of the shared VGA map BRAM and decides, each cycle, whether the

---
 rtl/vga_map_pkg.sv | 19 +
 rtl/vga_clear_sweeper.sv | 39 +++
 rtl/vga_map_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vga_map_write_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_map_pkg.sv
// Shared constants and encodings for the VGA map write path.
package vga_map_pkg;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 8;
    localparam int RF_DEPTH   = 307200;
    localparam int DISP_DEPTH = 110592;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef enum logic {
        MODE_RF   = 1'b0,
        MODE_DISP = 1'b1
    } mode_e;

endpackage

// File: rtl/vga_clear_sweeper.sv
// Clear-sweep address counter: walks 0..depth-1 once per sweep, restartable at any time.
module vga_clear_sweeper #(
    parameter int ADDR_W = vga_map_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] depth_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);
    import vga_map_pkg::*;

    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_o = (addr_q == depth_i - ADDR_W'(1));
    assign done_o = advance_i & last_o;
    assign addr_o = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (restart_i) begin
            addr_d = '0;
        end else if (advance_i) begin
            addr_d = last_o ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/vga_map_write_arbiter.sv
// Single owner of the VGA map BRAM write port: arbitrates rangefinder/disparity writers and
// sweeps the map clean after reset, mode change or clear request.
module vga_map_write_arbiter #(
    parameter int                          ADDR_W     = vga_map_pkg::ADDR_W,
    parameter int                          DATA_W     = vga_map_pkg::DATA_W,
    parameter int                          RF_DEPTH   = vga_map_pkg::RF_DEPTH,
    parameter int                          DISP_DEPTH = vga_map_pkg::DISP_DEPTH,
    parameter logic [vga_map_pkg::DATA_W-1:0] RF_CLR  = '0,
    parameter logic [vga_map_pkg::DATA_W-1:0] DISP_CLR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              clear_req,
    input  logic              rf_valid,
    input  logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              rf_ready,
    input  logic              disp_valid,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [DATA_W-1:0] disp_data,
    output logic              disp_ready,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic              busy,
    output logic              clear_done,
    output logic [7:0]        drop_cnt
);
    import vga_map_pkg::*;

    localparam logic [ADDR_W-1:0] RF_DEPTH_A   = ADDR_W'(RF_DEPTH);
    localparam logic [ADDR_W-1:0] DISP_DEPTH_A = ADDR_W'(DISP_DEPTH);

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic              mode_m_q, mode_s_q;
    logic              mode_chg, restart;
    logic [ADDR_W-1:0] depth;
    logic [DATA_W-1:0] clr_val;
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_last, sweep_done, sweep_adv;
    logic              own_valid;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic              wea_d, drop_inc;
    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [DATA_W-1:0] dina_d, dina_q;
    logic              wea_q, busy_q, done_q;
    logic [7:0]        drop_q;

    assign depth     = (mode_q == MODE_DISP) ? DISP_DEPTH_A : RF_DEPTH_A;
    assign clr_val   = (mode_q == MODE_DISP) ? DISP_CLR : RF_CLR;
    assign own_valid = (mode_q == MODE_DISP) ? disp_valid : rf_valid;
    assign own_addr  = (mode_q == MODE_DISP) ? disp_addr : rf_addr;
    assign own_data  = (mode_q == MODE_DISP) ? disp_data : rf_data;
    assign mode_chg  = (mode_s_q != mode_q);
    assign restart   = mode_chg | clear_req;

    // The mode switch is a raw, bouncy, asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_m_q <= 1'b0;
            mode_s_q <= 1'b0;
        end else begin
            mode_m_q <= mode;
            mode_s_q <= mode_m_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            mode_q  <= MODE_RF;
        end else begin
            state_q <= state_d;
            if (mode_chg) mode_q <= mode_e'(mode_s_q);
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_CLEAR;
        end else if (state_q == ST_CLEAR && sweep_last) begin
            state_d = ST_RUN;
        end
    end

    // A restart cycle issues nothing and accepts nothing; the sweep begins on the next cycle.
    always_comb begin
        rf_ready   = 1'b0;
        disp_ready = 1'b0;
        wea_d      = 1'b0;
        waddr_d    = waddr_q;
        dina_d     = dina_q;
        drop_inc   = 1'b0;
        sweep_adv  = 1'b0;
        if (!restart) begin
            case (state_q)
                ST_CLEAR: begin
                    wea_d     = 1'b1;
                    waddr_d   = sweep_addr;
                    dina_d    = clr_val;
                    sweep_adv = 1'b1;
                end
                ST_RUN: begin
                    rf_ready   = 1'b1;
                    disp_ready = 1'b1;
                    if (own_valid) begin
                        if (own_addr < depth) begin
                            wea_d   = 1'b1;
                            waddr_d = own_addr;
                            dina_d  = own_data;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    vga_clear_sweeper #(
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart_i (restart),
        .advance_i (sweep_adv),
        .depth_i   (depth),
        .addr_o    (sweep_addr),
        .last_o    (sweep_last),
        .done_o    (sweep_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wea_q   <= 1'b0;
            waddr_q <= '0;
            dina_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            wea_q   <= wea_d;
            waddr_q <= waddr_d;
            dina_q  <= dina_d;
            busy_q  <= (state_d == ST_CLEAR);
            done_q  <= sweep_done;
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign bram_waddr = waddr_q;
    assign bram_dina  = dina_q;
    assign bram_wea   = wea_q;
    assign bram_ena   = wea_q;
    assign busy       = busy_q;
    assign clear_done = done_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_vga_map_write_arbiter.sv
// Directed + randomized bench for vga_map_write_arbiter with shortened map depths.
module tb_vga_map_write_arbiter;

    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int RFD = 1000;
    localparam int DD  = 600;
    localparam logic [DW-1:0] RFC = 8'h5A;
    localparam logic [DW-1:0] DC  = 8'hC3;

    logic          clk;
    logic          reset_n;
    logic          mode;
    logic          clear_req;
    logic          rf_valid;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          rf_ready;
    logic          disp_valid;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_ready;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_dina;
    logic          bram_ena;
    logic          bram_wea;
    logic          busy;
    logic          clear_done;
    logic [7:0]    drop_cnt;

    vga_map_write_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RF_DEPTH   (RFD),
        .DISP_DEPTH (DD),
        .RF_CLR     (RFC),
        .DISP_CLR   (DC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .clear_req  (clear_req),
        .rf_valid   (rf_valid),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .rf_ready   (rf_ready),
        .disp_valid (disp_valid),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .bram_waddr (bram_waddr),
        .bram_dina  (bram_dina),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .busy       (busy),
        .clear_done (clear_done),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every BRAM write seen on the port, in order, as {addr, data}.
    logic [AW+DW-1:0] act_q[$];
    int done_seen = 0;
    int ena_bad   = 0;

    always @(negedge clk) begin
        if (bram_wea === 1'b1) act_q.push_back({bram_waddr, bram_dina});
        if (clear_done === 1'b1) done_seen++;
        if (bram_ena !== bram_wea) ena_bad++;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_req  = 1'b0;
        rf_valid   = 1'b0;
        disp_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s_wea", tag),   32'(bram_wea), 0);
        chk($sformatf("%s_ena", tag),   32'(bram_ena), 0);
        chk($sformatf("%s_waddr", tag), 32'(bram_waddr), 0);
        chk($sformatf("%s_dina", tag),  32'(bram_dina), 0);
        chk($sformatf("%s_busy", tag),  32'(busy), 0);
        chk($sformatf("%s_done", tag),  32'(clear_done), 0);
        chk($sformatf("%s_drop", tag),  32'(drop_cnt), 0);
        chk($sformatf("%s_rfrdy", tag), 32'(rf_ready), 0);
        chk($sformatf("%s_dsrdy", tag), 32'(disp_ready), 0);
    endtask

    // A clean sweep is exactly the writes 0..depth-1 of the clear value, then one done pulse.
    task automatic wait_sweep(input string tag, input int depth, input logic [DW-1:0] val,
                              input int base, input int done_base);
        int timed_out;
        int bad_rdy;
        int bad_busy;
        int bad;
        logic [AW-1:0] ia;
        timed_out = 1;
        bad_rdy   = 0;
        bad_busy  = 0;
        bad       = 0;
        for (int i = 0; i < depth + 20; i++) begin
            cyc();
            if (clear_done === 1'b1) begin
                timed_out = 0;
                break;
            end
            if (rf_ready !== 1'b0 || disp_ready !== 1'b0) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
        end
        @(negedge clk);
        #1;
        chk($sformatf("%s_timeout", tag), 32'(timed_out), 0);
        chk($sformatf("%s_ready_low", tag), 32'(bad_rdy), 0);
        chk($sformatf("%s_busy_high", tag), 32'(bad_busy), 0);
        chk($sformatf("%s_count", tag), 32'(act_q.size() - base), 32'(depth));
        for (int i = 0; i < depth; i++) begin
            ia = AW'(i);
            if (base + i >= act_q.size() || act_q[base + i] !== {ia, val}) bad++;
        end
        chk($sformatf("%s_contents", tag), 32'(bad), 0);
        chk($sformatf("%s_done_pulses", tag), 32'(done_seen - done_base), 1);
    endtask

    // Reference: every accepted owner write lands iff addr < depth; non-owner traffic vanishes.
    task automatic rand_run(input string tag, input int n, input int depth, input bit own_disp);
        logic [AW+DW-1:0] exp_q[$];
        int base;
        int bad_rdy;
        int bad;
        logic          ov;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        base    = act_q.size();
        bad_rdy = 0;
        bad     = 0;
        for (int i = 0; i < n; i++) begin
            rf_valid   = ($urandom_range(0, 3) != 0);
            rf_addr    = AW'($urandom_range(0, depth + depth / 8));
            rf_data    = DW'($urandom);
            disp_valid = ($urandom_range(0, 3) != 0);
            disp_addr  = AW'($urandom_range(0, depth + depth / 8));
            disp_data  = DW'($urandom);
            #1;
            if (rf_ready !== 1'b1 || disp_ready !== 1'b1) bad_rdy++;
            ov = own_disp ? disp_valid : rf_valid;
            oa = own_disp ? disp_addr : rf_addr;
            od = own_disp ? disp_data : rf_data;
            if (ov) begin
                if (int'(oa) < depth) exp_q.push_back({oa, od});
                else if (exp_drop < 255) exp_drop++;
            end
            cyc();
        end
        idle();
        @(negedge clk);
        #1;
        chk($sformatf("%s_ready", tag), 32'(bad_rdy), 0);
        chk($sformatf("%s_count", tag), 32'(act_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= act_q.size() || act_q[base + i] !== exp_q[i]) bad++;
        end
        chk($sformatf("%s_contents", tag), 32'(bad), 0);
        chk($sformatf("%s_drop_cnt", tag), 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int db;
        int got;
        int p;
        int bad;
        logic [AW-1:0] ia;

        reset_n   = 1'b0;
        mode      = 1'b0;
        rf_addr   = '0;
        rf_data   = '0;
        disp_addr = '0;
        disp_data = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Power-up sweep in rangefinder mode.
        base = act_q.size();
        db   = done_seen;
        reset_n = 1'b1;
        wait_sweep("t1_rf_sweep", RFD, RFC, base, db);
        chk("t1_rf_ready_after", 32'(rf_ready), 1);

        // Owner write with concurrent non-owner write.
        cyc();
        rf_valid = 1'b1; rf_addr = AW'(100); rf_data = 8'hFF;
        disp_valid = 1'b1; disp_addr = AW'(7); disp_data = 8'h77;
        #1;
        chk("t2_rf_ready", 32'(rf_ready), 1);
        chk("t2_disp_ready", 32'(disp_ready), 1);
        cyc();
        idle();
        chk("t2_waddr", 32'(bram_waddr), 100);
        chk("t2_dina", 32'(bram_dina), 32'hFF);
        chk("t2_wea", 32'(bram_wea), 1);
        chk("t2_ena", 32'(bram_ena), 1);
        cyc();
        chk("t2_idle_wea", 32'(bram_wea), 0);
        chk("t2_hold_waddr", 32'(bram_waddr), 100);
        chk("t2_hold_dina", 32'(bram_dina), 32'hFF);

        rand_run("t2_rand_rf", 200, RFD, 1'b0);

        // Switch to disparity mode.
        cyc();
        base = act_q.size();
        db   = done_seen;
        mode = 1'b1;
        got  = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (busy === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("t3_busy_within_3", 32'(got >= 1 && got <= 3), 1);
        wait_sweep("t3_disp_sweep", DD, DC, base, db);

        rand_run("t3_rand_disp", 200, DD, 1'b1);

        // Boundary address drops, then saturation.
        cyc();
        base = act_q.size();
        disp_valid = 1'b1; disp_addr = AW'(DD); disp_data = 8'h01;
        #1;
        chk("t5_disp_ready", 32'(disp_ready), 1);
        if (exp_drop < 255) exp_drop++;
        cyc();
        idle();
        chk("t5_no_wea", 32'(bram_wea), 0);
        chk("t5_drop_one", 32'(drop_cnt), 32'(exp_drop));
        for (int i = 0; i < 300; i++) begin
            disp_valid = 1'b1;
            disp_addr  = AW'(DD + (i % 40));
            disp_data  = DW'(i);
            cyc();
        end
        idle();
        cyc();
        @(negedge clk);
        #1;
        chk("t5_drop_sat", 32'(drop_cnt), 255);
        chk("t5_no_writes", 32'(act_q.size() - base), 0);

        // Mode change mid-sweep restarts with the other mode's depth and value.
        cyc();
        base = act_q.size();
        db   = done_seen;
        mode = 1'b0;
        for (int i = 0; i < 400 && (act_q.size() - base) < 300; i++) cyc();
        mode = 1'b1;
        got = 0;
        for (int i = 0; i < RFD + DD + 50; i++) begin
            cyc();
            if (clear_done === 1'b1) begin
                got = 1;
                break;
            end
        end
        @(negedge clk);
        #1;
        chk("t4_finished", 32'(got), 1);
        p = act_q.size() - base - DD;
        chk("t4_prefix_len", 32'(p >= 300 && p <= 310), 1);
        bad = 0;
        if (p >= 0) begin
            for (int i = 0; i < p; i++) begin
                ia = AW'(i);
                if (act_q[base + i] !== {ia, RFC}) bad++;
            end
            for (int i = 0; i < DD; i++) begin
                ia = AW'(i);
                if (act_q[base + p + i] !== {ia, DC}) bad++;
            end
        end
        chk("t4_contents", 32'(bad), 0);
        chk("t4_done_pulses", 32'(done_seen - db), 1);

        // clear_req beats a simultaneous owner write.
        cyc();
        base = act_q.size();
        db   = done_seen;
        clear_req = 1'b1;
        disp_valid = 1'b1; disp_addr = AW'(10); disp_data = 8'hEE;
        #1;
        chk("t6_disp_ready_low", 32'(disp_ready), 0);
        chk("t6_rf_ready_low", 32'(rf_ready), 0);
        cyc();
        idle();
        chk("t6_not_issued", 32'(bram_wea), 0);
        chk("t6_busy", 32'(busy), 1);
        wait_sweep("t6_clear_sweep", DD, DC, base, db);

        // Asynchronous reset in the middle of a sweep.
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (50) cyc();
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        mode = 1'b0;
        cyc();
        cyc();
        base = act_q.size();
        db   = done_seen;
        reset_n = 1'b1;
        wait_sweep("t6_post_reset", RFD, RFC, base, db);

        chk("ena_equals_wea", 32'(ena_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
